// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU instruction/data request ports and the external memory port
// that the arbiter sits between.
interface mem_port_arbiter_if #(
    parameter int WORD = 16
);
    logic            i_req;
    logic [WORD-1:0] i_address;
    logic            i_done;
    logic [WORD-1:0] i_rdata;

    logic            d_req;
    logic            d_we;
    logic [WORD-1:0] d_address;
    logic [WORD-1:0] d_wdata;
    logic            d_done;
    logic [WORD-1:0] d_rdata;

    logic            mem_readM;
    logic            mem_writeM;
    logic [WORD-1:0] mem_address;
    logic [WORD-1:0] mem_wdata;
    logic [WORD-1:0] mem_rdata;

    logic            busy;
    logic            owner_d;

    // Arbiter side
    modport slave (
        input  i_req, i_address, d_req, d_we, d_address, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
        output mem_readM, mem_writeM, mem_address, mem_wdata, busy, owner_d
    );

    // Requesters plus memory model side
    modport master (
        output i_req, i_address, d_req, d_we, d_address, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  mem_readM, mem_writeM, mem_address, mem_wdata, busy, owner_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises I-side reads and D-side reads/writes onto one fixed-latency memory,
// D-side first, with a streak limit so a waiting I-side fetch always gets through.
module mem_port_arbiter #(
    parameter int WORD         = 16,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                Clk,
    input  logic                Reset_N,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STK_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_reg,   state_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [STK_W-1:0]  streak_reg,  streak_next;
    logic              owner_d_reg, owner_d_next;
    logic              we_reg,      we_next;
    logic [WORD-1:0]   addr_reg,    addr_next;
    logic [WORD-1:0]   wdata_reg,   wdata_next;
    logic [WORD-1:0]   i_rdata_reg, i_rdata_next;
    logic [WORD-1:0]   d_rdata_reg, d_rdata_next;
    logic              grant_d;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            streak_reg  <= '0;
            owner_d_reg <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            streak_reg  <= streak_next;
            owner_d_reg <= owner_d_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            i_rdata_reg <= i_rdata_next;
            d_rdata_reg <= d_rdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        streak_next  = streak_reg;
        owner_d_next = owner_d_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        i_rdata_next = i_rdata_reg;
        d_rdata_next = d_rdata_reg;
        grant_d      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.d_req || bus.i_req) begin
                    // D wins unless the I-side has already waited out the streak limit
                    grant_d      = bus.d_req && !(bus.i_req && (streak_reg == STK_MAX));
                    owner_d_next = grant_d;
                    cnt_next     = CNT_LOAD;
                    state_next   = ACCESS;
                    if (grant_d) begin
                        addr_next  = bus.d_address;
                        we_next    = bus.d_we;
                        wdata_next = bus.d_wdata;
                        if (bus.i_req)
                            streak_next = (streak_reg == STK_MAX) ? streak_reg
                                                                  : streak_reg + STK_W'(1);
                        else
                            streak_next = '0;
                    end else begin
                        addr_next   = bus.i_address;
                        we_next     = 1'b0;
                        streak_next = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_reg == '0) begin
                    if (!(owner_d_reg && we_reg)) begin
                        if (owner_d_reg) d_rdata_next = bus.mem_rdata;
                        else             i_rdata_next = bus.mem_rdata;
                    end
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_readM   = (state_reg == ACCESS) && !(owner_d_reg && we_reg);
    assign bus.mem_writeM  = (state_reg == ACCESS) && owner_d_reg && we_reg;
    assign bus.mem_address = addr_reg;
    assign bus.mem_wdata   = wdata_reg;
    assign bus.i_done      = (state_reg == DONE) && !owner_d_reg;
    assign bus.d_done      = (state_reg == DONE) && owner_d_reg;
    assign bus.i_rdata     = i_rdata_reg;
    assign bus.d_rdata     = d_rdata_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.owner_d     = owner_d_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized request mixes against a
// transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;
    logic Clk = 1'b0;
    logic Reset_N = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(.WORD(16)) ifa ();
    mem_port_arbiter_if #(.WORD(16)) ifb ();

    mem_port_arbiter #(.WORD(16), .LATENCY(2), .STARVE_LIMIT(3)) dut_a (
        .Clk(Clk), .Reset_N(Reset_N), .bus(ifa.slave));
    mem_port_arbiter #(.WORD(16), .LATENCY(1), .STARVE_LIMIT(3)) dut_b (
        .Clk(Clk), .Reset_N(Reset_N), .bus(ifb.slave));

    // External memory models: preload image plus write-back storage for DUT A
    logic [15:0] pre_a [1024];
    logic [15:0] wr_a  [1024];
    bit          wv_a  [1024];
    logic [15:0] pre_b [1024];
    logic [15:0] shad_a [1024];

    assign ifa.mem_rdata = wv_a[ifa.mem_address[9:0]] ? wr_a[ifa.mem_address[9:0]]
                                                      : pre_a[ifa.mem_address[9:0]];
    assign ifb.mem_rdata = pre_b[ifb.mem_address[9:0]];

    always @(posedge Clk) begin
        if (ifa.mem_writeM) begin
            wr_a[ifa.mem_address[9:0]] <= ifa.mem_wdata;
            wv_a[ifa.mem_address[9:0]] <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        logic [69:0] va, vb;
        Reset_N = 1'b0;
        repeat (2) cyc();
        #1;
        va = {ifa.i_done, ifa.d_done, ifa.mem_readM, ifa.mem_writeM, ifa.busy, ifa.owner_d,
              ifa.i_rdata, ifa.d_rdata, ifa.mem_address, ifa.mem_wdata};
        vb = {ifb.i_done, ifb.d_done, ifb.mem_readM, ifb.mem_writeM, ifb.busy, ifb.owner_d,
              ifb.i_rdata, ifb.d_rdata, ifb.mem_address, ifb.mem_wdata};
        n_checks++; if (va !== '0) begin n_fail++; $display("FAIL reset_outputs_a: got %h want 0", va); end
        n_checks++; if (vb !== '0) begin n_fail++; $display("FAIL reset_outputs_b: got %h want 0", vb); end
        cyc();
        Reset_N = 1'b1;
        cyc(); #1;
        n_checks++; if (ifa.busy !== 1'b0 || ifa.mem_readM !== 1'b0)
            begin n_fail++; $display("FAIL idle_after_reset: busy=%b readM=%b want 0 0", ifa.busy, ifa.mem_readM); end
        $display("reset: outputs checked zero during and after reset");
    endtask

    task automatic test_i_read();
        ifa.i_address = 16'h0040;
        ifa.i_req     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc(); #1;
            if (c <= 2) begin
                n_checks++; if (ifa.mem_readM !== 1'b1 || ifa.mem_writeM !== 1'b0)
                    begin n_fail++; $display("FAIL i_read_strobe c%0d: readM=%b writeM=%b want 1 0", c, ifa.mem_readM, ifa.mem_writeM); end
                n_checks++; if (ifa.mem_address !== 16'h0040)
                    begin n_fail++; $display("FAIL i_read_addr c%0d: got %h want 0040", c, ifa.mem_address); end
                n_checks++; if (ifa.i_done !== 1'b0)
                    begin n_fail++; $display("FAIL i_read_early_done c%0d: got %b want 0", c, ifa.i_done); end
            end else if (c == 3) begin
                n_checks++; if (ifa.i_done !== 1'b1 || ifa.d_done !== 1'b0)
                    begin n_fail++; $display("FAIL i_read_done: i_done=%b d_done=%b want 1 0", ifa.i_done, ifa.d_done); end
                n_checks++; if (ifa.i_rdata !== 16'h1234)
                    begin n_fail++; $display("FAIL i_read_data: got %h want 1234", ifa.i_rdata); end
                n_checks++; if (ifa.mem_readM !== 1'b0)
                    begin n_fail++; $display("FAIL i_read_done_strobe: got %b want 0", ifa.mem_readM); end
                ifa.i_req = 1'b0;
            end else begin
                n_checks++; if (ifa.busy !== 1'b0)
                    begin n_fail++; $display("FAIL i_read_busy_c4: got %b want 0", ifa.busy); end
            end
        end
        $display("i_read: addr 0040 -> 1234");
    endtask

    task automatic test_both_read();
        ifa.i_address = 16'h0010;
        ifa.d_address = 16'h0020;
        ifa.d_we      = 1'b0;
        ifa.i_req     = 1'b1;
        ifa.d_req     = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc(); #1;
            case (c)
                1: begin
                    n_checks++; if (ifa.owner_d !== 1'b1 || ifa.mem_address !== 16'h0020 || ifa.mem_readM !== 1'b1)
                        begin n_fail++; $display("FAIL both_first_grant: owner_d=%b addr=%h readM=%b want 1 0020 1", ifa.owner_d, ifa.mem_address, ifa.mem_readM); end
                end
                3: begin
                    n_checks++; if (ifa.d_done !== 1'b1 || ifa.i_done !== 1'b0)
                        begin n_fail++; $display("FAIL both_d_done: d_done=%b i_done=%b want 1 0", ifa.d_done, ifa.i_done); end
                    n_checks++; if (ifa.d_rdata !== 16'h5555)
                        begin n_fail++; $display("FAIL both_d_data: got %h want 5555", ifa.d_rdata); end
                    n_checks++; if (ifa.i_rdata !== 16'h1234)
                        begin n_fail++; $display("FAIL both_i_untouched: got %h want 1234", ifa.i_rdata); end
                    ifa.d_req = 1'b0;
                end
                4: begin
                    n_checks++; if (ifa.busy !== 1'b0)
                        begin n_fail++; $display("FAIL both_idle_c4: busy=%b want 0", ifa.busy); end
                end
                5: begin
                    n_checks++; if (ifa.owner_d !== 1'b0 || ifa.mem_address !== 16'h0010)
                        begin n_fail++; $display("FAIL both_second_grant: owner_d=%b addr=%h want 0 0010", ifa.owner_d, ifa.mem_address); end
                end
                7: begin
                    n_checks++; if (ifa.i_done !== 1'b1 || ifa.d_done !== 1'b0)
                        begin n_fail++; $display("FAIL both_i_done: i_done=%b d_done=%b want 1 0", ifa.i_done, ifa.d_done); end
                    n_checks++; if (ifa.i_rdata !== 16'hAAAA || ifa.d_rdata !== 16'h5555)
                        begin n_fail++; $display("FAIL both_i_data: i_rdata=%h d_rdata=%h want aaaa 5555", ifa.i_rdata, ifa.d_rdata); end
                    ifa.i_req = 1'b0;
                end
                8: begin
                    n_checks++; if (ifa.busy !== 1'b0)
                        begin n_fail++; $display("FAIL both_idle_c8: busy=%b want 0", ifa.busy); end
                end
                default: ;
            endcase
        end
        $display("both_read: D(0020)=5555 first, then I(0010)=aaaa");
    endtask

    task automatic test_d_write();
        int dones = 0;
        ifa.d_address = 16'h0100;
        ifa.d_wdata   = 16'hBEEF;
        ifa.d_we      = 1'b1;
        ifa.d_req     = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc(); #1;
            if (ifa.d_done === 1'b1) dones++;
            if (c <= 2) begin
                n_checks++; if (ifa.mem_writeM !== 1'b1 || ifa.mem_readM !== 1'b0)
                    begin n_fail++; $display("FAIL d_write_strobe c%0d: writeM=%b readM=%b want 1 0", c, ifa.mem_writeM, ifa.mem_readM); end
                n_checks++; if (ifa.mem_address !== 16'h0100 || ifa.mem_wdata !== 16'hBEEF)
                    begin n_fail++; $display("FAIL d_write_bus c%0d: addr=%h wdata=%h want 0100 beef", c, ifa.mem_address, ifa.mem_wdata); end
            end else if (c == 3) begin
                n_checks++; if (ifa.d_done !== 1'b1 || ifa.mem_writeM !== 1'b0)
                    begin n_fail++; $display("FAIL d_write_done: d_done=%b writeM=%b want 1 0", ifa.d_done, ifa.mem_writeM); end
                n_checks++; if (ifa.d_rdata !== 16'h5555)
                    begin n_fail++; $display("FAIL d_write_rdata_held: got %h want 5555", ifa.d_rdata); end
                ifa.d_req = 1'b0;
                ifa.d_we  = 1'b0;
                shad_a[10'h100] = 16'hBEEF;
            end
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL d_write_pulses: got %0d want 1", dones); end
        $display("d_write: 0100 <= beef");
    endtask

    task automatic test_starvation();
        bit got_d, exp_d, found;
        ifa.i_address = 16'h0040;
        ifa.d_address = 16'h0100;
        ifa.d_we      = 1'b0;
        ifa.i_req     = 1'b1;
        ifa.d_req     = 1'b1;
        for (int g = 0; g < 8; g++) begin
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                cyc(); #1;
                if (ifa.i_done === 1'b1 || ifa.d_done === 1'b1) found = 1'b1;
            end
            n_checks++;
            if (!found) begin
                n_fail++; $display("FAIL starve_timeout grant %0d: no done within 10 cycles", g);
                break;
            end
            got_d = ifa.d_done;
            exp_d = ((g % 4) != 3);
            if (got_d !== exp_d || ifa.i_done !== !exp_d) begin
                n_fail++; $display("FAIL starve_order grant %0d: d_done=%b i_done=%b want d=%b", g, ifa.d_done, ifa.i_done, exp_d);
            end
            n_checks++;
            if (exp_d ? (ifa.d_rdata !== 16'hBEEF) : (ifa.i_rdata !== 16'h1234)) begin
                n_fail++; $display("FAIL starve_data grant %0d: d_rdata=%h i_rdata=%h want %s", g, ifa.d_rdata, ifa.i_rdata, exp_d ? "d=beef" : "i=1234");
            end
            $display("starvation: grant %0d -> %s", g, got_d ? "D" : "I");
        end
        ifa.i_req = 1'b0;
        ifa.d_req = 1'b0;
        cyc(); #1;
        n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL starve_idle: busy=%b want 0", ifa.busy); end
    endtask

    task automatic test_reset_mid();
        logic [69:0] va;
        int dones = 0;
        ifa.d_address = 16'h0033;
        ifa.d_we      = 1'b0;
        ifa.d_req     = 1'b1;
        cyc();
        cyc(); #1;
        Reset_N   = 1'b0;
        ifa.d_req = 1'b0;
        #1;
        va = {ifa.i_done, ifa.d_done, ifa.mem_readM, ifa.mem_writeM, ifa.busy, ifa.owner_d,
              ifa.i_rdata, ifa.d_rdata, ifa.mem_address, ifa.mem_wdata};
        n_checks++; if (va !== '0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h want 0", va); end
        cyc();
        Reset_N = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc(); #1;
            if (ifa.i_done === 1'b1 || ifa.d_done === 1'b1 || ifa.busy === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL reset_mid_ghost: %0d cycles with done/busy want 0", dones); end
        ifa.i_address = 16'h0040;
        ifa.i_req     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc(); #1;
            if (c == 3) begin
                n_checks++; if (ifa.i_done !== 1'b1 || ifa.i_rdata !== 16'h1234)
                    begin n_fail++; $display("FAIL reset_mid_fresh: i_done=%b i_rdata=%h want 1 1234", ifa.i_done, ifa.i_rdata); end
                ifa.i_req = 1'b0;
            end
        end
        $display("reset_mid: access abandoned, fresh read completed");
    endtask

    task automatic test_lat1();
        ifb.i_address = 16'h0007;
        ifb.i_req     = 1'b1;
        cyc(); #1;
        n_checks++; if (ifb.mem_readM !== 1'b1 || ifb.mem_address !== 16'h0007)
            begin n_fail++; $display("FAIL lat1_strobe: readM=%b addr=%h want 1 0007", ifb.mem_readM, ifb.mem_address); end
        ifb.i_address = 16'h0099;
        #1;
        n_checks++; if (ifb.mem_address !== 16'h0007)
            begin n_fail++; $display("FAIL lat1_addr_hold: got %h want 0007", ifb.mem_address); end
        cyc(); #1;
        n_checks++; if (ifb.i_done !== 1'b1 || ifb.i_rdata !== 16'hCAFE || ifb.mem_readM !== 1'b0)
            begin n_fail++; $display("FAIL lat1_done: i_done=%b i_rdata=%h readM=%b want 1 cafe 0", ifb.i_done, ifb.i_rdata, ifb.mem_readM); end
        ifb.i_req = 1'b0;
        cyc(); #1;
        n_checks++; if (ifb.busy !== 1'b0)
            begin n_fail++; $display("FAIL lat1_idle: busy=%b want 0", ifb.busy); end
        $display("lat1: addr 0007 -> cafe in cycle 2");
    endtask

    task automatic test_random(input int iters);
        bit pend_i, pend_d, win_d, found, stop;
        int streak, grants;
        logic [15:0] ia, da, wd, exp_i, exp_d;
        bit we;
        cyc(); Reset_N = 1'b0;
        cyc(); Reset_N = 1'b1;
        exp_i = '0; exp_d = '0; streak = 0; stop = 1'b0;
        for (int it = 0; it < iters && !stop; it++) begin
            cyc();
            pend_i = $urandom_range(0, 1);
            pend_d = $urandom_range(0, 1);
            if (!pend_i && !pend_d) pend_d = 1'b1;
            ia = 16'($urandom_range(0, 255)); da = 16'($urandom_range(0, 255));
            we = $urandom_range(0, 1); wd = 16'($urandom);
            ifa.i_address = ia; ifa.d_address = da; ifa.d_we = we; ifa.d_wdata = wd;
            ifa.i_req = pend_i; ifa.d_req = pend_d;
            grants = 0;
            while ((pend_i || pend_d) && !stop) begin
                win_d = pend_d && !(pend_i && streak == 3);
                if (win_d) streak = pend_i ? ((streak < 3) ? streak + 1 : 3) : 0;
                else       streak = 0;
                found = 1'b0;
                for (int k = 0; k < 8 && !found; k++) begin
                    cyc(); #1;
                    if (ifa.i_done === 1'b1 || ifa.d_done === 1'b1) found = 1'b1;
                end
                n_checks++;
                if (!found) begin
                    n_fail++; $display("FAIL rand_timeout it %0d: no done within 8 cycles", it);
                    ifa.i_req = 1'b0; ifa.d_req = 1'b0; stop = 1'b1;
                    break;
                end
                if ({ifa.i_done, ifa.d_done} !== (win_d ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL rand_winner it %0d: i_done=%b d_done=%b want d=%b", it, ifa.i_done, ifa.d_done, win_d);
                end
                if (win_d) begin
                    if (we) shad_a[da[9:0]] = wd;
                    else    exp_d = shad_a[da[9:0]];
                end else begin
                    exp_i = shad_a[ia[9:0]];
                end
                n_checks++;
                if (ifa.i_rdata !== exp_i || ifa.d_rdata !== exp_d) begin
                    n_fail++; $display("FAIL rand_data it %0d: i_rdata=%h d_rdata=%h want %h %h", it, ifa.i_rdata, ifa.d_rdata, exp_i, exp_d);
                end
                $display("random it %0d grant %0d: %s %s addr=%h", it, grants, win_d ? "D" : "I",
                         (win_d && we) ? "write" : "read", win_d ? da : ia);
                grants++;
                if (win_d) begin
                    if (pend_i && grants < 12 && $urandom_range(0, 2) != 0) begin
                        da = 16'($urandom_range(0, 255)); we = $urandom_range(0, 1); wd = 16'($urandom);
                        ifa.d_address = da; ifa.d_we = we; ifa.d_wdata = wd;
                    end else begin
                        pend_d = 1'b0; ifa.d_req = 1'b0;
                    end
                end else begin
                    pend_i = 1'b0; ifa.i_req = 1'b0;
                end
            end
        end
        cyc(); #1;
        n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL rand_final_idle: busy=%b want 0", ifa.busy); end
    endtask

    initial begin
        ifa.i_req = 1'b0; ifa.i_address = '0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
        ifa.d_address = '0; ifa.d_wdata = '0;
        ifb.i_req = 1'b0; ifb.i_address = '0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
        ifb.d_address = '0; ifb.d_wdata = '0;
        for (int k = 0; k < 1024; k++) begin
            pre_a[k]  = 16'(k * 37 + 5) ^ 16'h3C00;
            shad_a[k] = pre_a[k];
            pre_b[k]  = 16'(k * 11 + 1);
        end
        pre_a[16'h0040] = 16'h1234; shad_a[16'h0040] = 16'h1234;
        pre_a[16'h0010] = 16'hAAAA; shad_a[16'h0010] = 16'hAAAA;
        pre_a[16'h0020] = 16'h5555; shad_a[16'h0020] = 16'h5555;
        pre_b[16'h0007] = 16'hCAFE;

        test_reset();
        test_i_read();
        test_both_read();
        test_d_write();
        test_starvation();
        test_reset_mid();
        test_lat1();
        test_random(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipelined CPU's instruction-fetch side and data side (I-side read-only, D-side read/write).
- Serialises the two requesters over a request/done handshake and sequences each access with a latency counter.
- Gives the D-side priority, with a starvation limit that guarantees the I-side forward progress.
- Sits between the CPU's instruction and data memory interfaces and the external memory model.

Parameters:
- WORD, 16, data and address width in bits.
- LATENCY, 2, memory access latency in cycles; must be ≥1.
- STARVE_LIMIT, 3, maximum number of consecutive D grants while i_req is pending; must be ≥1.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset_N  in  1  asynchronous active-low reset.
- i_req  in  1  I-side read request; held until i_done.
- i_address  in  WORD  I-side word address.
- i_done  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  WORD  I-side read data; registered, holds last value.
- d_req  in  1  D-side request; held until d_done.
- d_we  in  1  D-side request type: 1 = write, 0 = read.
- d_address  in  WORD  D-side word address.
- d_wdata  in  WORD  D-side write data.
- d_done  out  1  one-cycle completion pulse.
- d_rdata  out  WORD  D-side read data; registered, updated only on D reads.
- mem_readM  out  1  memory read strobe.
- mem_writeM  out  1  memory write strobe.
- mem_address  out  WORD  memory address.
- mem_wdata  out  WORD  memory write data.
- mem_rdata  in  WORD  memory read data; valid in the last ACCESS cycle.
- busy  out  1  high in ACCESS and DONE.
- owner_d  out  1  1 when the current or last grant went to the D-side.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (asynchronous, any state, including mid-access):
  - state goes to IDLE.
  - All outputs go to 0: strobes, done pulses, rdata registers, mem_address, mem_wdata, owner_d, busy.
  - Streak counter goes to 0.
  - An in-flight access is abandoned; no done pulse is issued after reset releases.
- IDLE:
  - With no request, strobes stay 0.
  - When a request is present, the arbiter picks a winner and latches its address, we and wdata.
  - It then loads cnt = LATENCY-1 and moves to ACCESS.
- Arbitration, evaluated only in IDLE:
  - Only d_req → D wins.
  - Only i_req → I wins.
  - Both requests and streak < STARVE_LIMIT → D wins.
  - Both requests and streak == STARVE_LIMIT → I wins.
  - Streak update: a D grant with i_req high increments streak, saturating at STARVE_LIMIT. A D grant with i_req low clears streak. Any I grant clears streak.
- ACCESS:
  - Lasts exactly LATENCY cycles.
  - mem_address/mem_wdata hold the latched values, constant for the whole access.
  - mem_readM = 1 for I grants and D reads; mem_writeM = 1 for D writes; never both.
  - cnt decrements each cycle.
  - In the cycle where cnt == 0: for a read, mem_rdata is captured into i_rdata or d_rdata at the edge; the state then moves to DONE.
- DONE:
  - One cycle; strobes are 0.
  - The winner's done pulses high: i_done or d_done, never both.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 → strobes high in cycles 1..LATENCY → done in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
  - Peak throughput is one access per LATENCY+2 cycles.
- Handshake rules:
  - Requester inputs are ignored outside IDLE; latched values are immune to input changes mid-access.
  - A requester must drop req or present a new request at the edge ending its done cycle. Any req high in the following IDLE cycle is treated as a new request.
- The non-served requester's rdata and done are unaffected by the other requester's accesses.
- D writes leave d_rdata unchanged.

Test Plan:
- I read, LATENCY=2, mem_rdata=16'h1234 at address 16'h0040, i_req high at cycle 0.
  → mem_readM=1 with mem_address=16'h0040 in cycles 1–2; i_done=1 and i_rdata=16'h1234 in cycle 3; busy=0 in cycle 4.
- D write: d_req=1, d_we=1, d_address=16'h0100, d_wdata=16'hBEEF.
  → mem_writeM=1 and mem_readM=0 for 2 cycles with those values; d_done pulses once; d_rdata unchanged.
- i_req and d_req rise together, both reads.
  → D served first (owner_d=1, d_done in cycle 3); I granted in cycle 4; i_done in cycle 7.
- Starvation, STARVE_LIMIT=3: d_req held high continuously (re-requested every IDLE) while i_req stays high.
  → grant order D, D, D, I, D…; streak cleared after the I grant.
- Reset_N pulled low in the 2nd ACCESS cycle.
  → all outputs 0 immediately; no done pulse after release; a fresh request afterwards completes normally.
- LATENCY=1 boundary: a single read gives a 1-cycle strobe and done in cycle 2. Changing i_address mid-access leaves mem_address unchanged.
